mem_arbiter: RTL and testbench

Two-master, one-slave arbiter for the microcoded core's `valid`/`ready` memory bus. It lets the core's memory port (master 0) and a second requester, such as a loader, debug or DMA engine (master 1), share one memory. Arbitration is round-robin, and a granted transaction holds until `mem_ready` arrives or until a bus timeout fires. On a timeout the arbiter completes the transaction itself with an error word, so a missing slave cannot hang the core.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets two valid/ready masters share one memory slave.
// A transaction whose slave never answers is completed locally with ERR_DATA.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        bus_error,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  logic busy;
  logic done_ok;
  logic done_to;
  logic pick_m0;

  assign busy    = (state_q == BUSY0) || (state_q == BUSY1);
  assign done_ok = busy && mem_ready;
  // A slave answer in the final cycle beats the timeout.
  assign done_to = busy && !mem_ready && (tcnt_q == TCNT_LAST);
  assign pick_m0 = m0_valid && (!m1_valid || last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      tcnt_q      <= 8'd0;
      err_count_q <= 8'd0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      tcnt_q      <= tcnt_d;
      err_count_q <= err_count_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    tcnt_d      = tcnt_q;
    err_count_d = err_count_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: begin
        if (pick_m0) begin
          state_d     = BUSY0;
          tcnt_d      = 8'd0;
          mem_valid_d = 1'b1;
          mem_addr_d  = m0_addr;
          mem_wdata_d = m0_wdata;
          mem_wstrb_d = m0_wstrb;
        end else if (m1_valid) begin
          state_d     = BUSY1;
          tcnt_d      = 8'd0;
          mem_valid_d = 1'b1;
          mem_addr_d  = m1_addr;
          mem_wdata_d = m1_wdata;
          mem_wstrb_d = m1_wstrb;
        end
      end
      BUSY0, BUSY1: begin
        tcnt_d = tcnt_q + 8'd1;
        if (done_ok || done_to) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          last_d      = (state_q == BUSY1);
        end
        if (done_to && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    grant     = 2'b00;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = 32'd0;
    m1_rdata  = 32'd0;
    bus_error = done_to;
    if (state_q == BUSY0) begin
      grant    = 2'b01;
      m0_ready = done_ok || done_to;
      if (m0_ready) m0_rdata = mem_ready ? mem_rdata : ERR_DATA;
    end else if (state_q == BUSY1) begin
      grant    = 2'b10;
      m1_ready = done_ok || done_to;
      if (m1_ready) m1_rdata = mem_ready ? mem_rdata : ERR_DATA;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a latency-programmable slave model and
// per-master completion scoreboards.
module tb_mem_arbiter;

  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'hCAFEF00D;
  logic [1:0]  grant;
  logic        bus_error;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  // Slave behaviour: answer in BUSY cycle slave_lat (0 = never answer).
  int          slave_lat = 1;
  bit          slave_fixed = 1'b0;
  logic [31:0] slave_data = '0;
  int          bc = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [1:0]  obs_grant[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_wdata[$];
  logic [3:0]  obs_wstrb[$];
  logic [1:0]  prev_grant = 2'b00;

  mem_arbiter #(.TIMEOUT(4), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .bus_error(bus_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sdat(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst || !mem_valid) begin
      bc = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'hCAFEF00D;
    end else begin
      bc++;
      mem_ready = (slave_lat != 0) && (bc == slave_lat);
      mem_rdata = slave_fixed ? slave_data : sdat(mem_addr);
    end
  end

  // Completion scoreboard: each ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (m0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("[TB] FAIL m0_unexpected_ready: got rdata=%h, required no pulse", m0_rdata);
        end else begin
          e = q0.pop_front();
          if ({bus_error, m0_rdata} !== e) begin
            failures++;
            $display("[TB] FAIL m0_completion: got err=%b rdata=%h, required err=%b rdata=%h",
                     bus_error, m0_rdata, e[32], e[31:0]);
          end
        end
      end
      if (m1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("[TB] FAIL m1_unexpected_ready: got rdata=%h, required no pulse", m1_rdata);
        end else begin
          e = q1.pop_front();
          if ({bus_error, m1_rdata} !== e) begin
            failures++;
            $display("[TB] FAIL m1_completion: got err=%b rdata=%h, required err=%b rdata=%h",
                     bus_error, m1_rdata, e[32], e[31:0]);
          end
        end
      end
      if (bus_error && !m0_ready && !m1_ready) begin
        checks++;
        failures++;
        $display("[TB] FAIL stray_bus_error: got bus_error=1 without ready, required 0");
      end
    end
  end

  // Records the start of every grant and checks the idle gap between owners.
  always @(negedge clk) begin
    if (rst) begin
      prev_grant = 2'b00;
    end else begin
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        obs_grant.push_back(grant);
        obs_addr.push_back(mem_addr);
        obs_wdata.push_back(mem_wdata);
        obs_wstrb.push_back(mem_wstrb);
      end
      if (grant != 2'b00 && prev_grant != 2'b00 && grant != prev_grant) begin
        checks++;
        failures++;
        $display("[TB] FAIL grant_no_idle: got %b after %b, required idle gap", grant, prev_grant);
      end
      prev_grant = grant;
    end
  end

  task automatic clear_obs();
    obs_grant.delete();
    obs_addr.delete();
    obs_wdata.delete();
    obs_wstrb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] ed, input logic ee);
    bit got = 1'b0;
    if (m == 0) begin
      q0.push_back({ee, ed});
      m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_valid = 1'b1;
    end else begin
      q1.push_back({ee, ed});
      m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_valid = 1'b1;
    end
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ready : m1_ready;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL req_handshake m%0d addr=%h: got no ready in 64 cycles, required ready", m, a);
    end
    @(posedge clk);
    #1;
    if (m == 0) m0_valid = 1'b0;
    else m1_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_valid, grant, bus_error, m0_ready, m1_ready, err_count} !== 14'd0 ||
        {mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got valid=%b grant=%b err=%b rdy=%b%b cnt=%0d addr=%h, required all 0",
               mem_valid, grant, bus_error, m0_ready, m1_ready, err_count, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_m0_read();
    slave_fixed = 1'b1;
    slave_data  = 32'h12345678;
    slave_lat   = 2;
    fork
      drive_req(0, 32'h100, 32'h0, 4'h0, 32'h12345678, 1'b0);
      begin
        bit seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
          @(negedge clk);
          seen = mem_valid;
        end
        checks++;
        if (!seen || mem_addr !== 32'h100 || grant !== 2'b01 || mem_wstrb !== 4'h0 ||
            m1_ready !== 1'b0 || m1_rdata !== 32'd0) begin
          failures++;
          $display("[TB] FAIL m0_read_busy: got valid=%b addr=%h grant=%b wstrb=%h m1_ready=%b, required 1 100 01 0 0",
                   mem_valid, mem_addr, grant, mem_wstrb, m1_ready);
        end
        m0_addr = 32'hFFF;
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h100 || m0_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL m0_read_latch: got addr=%h m0_ready=%b, required addr=100 m0_ready=1",
                   mem_addr, m0_ready);
        end
      end
    join
    slave_fixed = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    slave_lat = 1;
    fork
      drive_req(0, 32'h10, 32'h0, 4'h0, sdat(32'h10), 1'b0);
      drive_req(1, 32'h20, 32'h0, 4'h0, sdat(32'h20), 1'b0);
    join
    @(negedge clk);
    checks++;
    if (obs_grant.size() != 2 || obs_grant[0] !== 2'b01 || obs_grant[1] !== 2'b10 ||
        obs_addr[0] !== 32'h10 || obs_addr[1] !== 32'h20) begin
      failures++;
      $display("[TB] FAIL simultaneous_order: got %0d grants %p addrs %p, required 01@10 then 10@20",
               obs_grant.size(), obs_grant, obs_addr);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    slave_lat = 1;
    fork
      begin
        drive_req(0, 32'h200, 32'h0, 4'h0, sdat(32'h200), 1'b0);
        drive_req(0, 32'h204, 32'h0, 4'h0, sdat(32'h204), 1'b0);
      end
      begin
        drive_req(1, 32'h300, 32'h0000BEEF, 4'b0011, sdat(32'h300), 1'b0);
        drive_req(1, 32'h304, 32'h0, 4'h0, sdat(32'h304), 1'b0);
      end
    join
    @(negedge clk);
    checks++;
    if (obs_grant.size() != 4 || obs_grant[0] !== 2'b01 || obs_grant[1] !== 2'b10 ||
        obs_grant[2] !== 2'b01 || obs_grant[3] !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rr_order: got %0d grants %p, required 01 10 01 10", obs_grant.size(), obs_grant);
    end else begin
      checks++;
      if (obs_addr[1] !== 32'h300 || obs_wstrb[1] !== 4'b0011 || obs_wdata[1] !== 32'h0000BEEF ||
          obs_addr[2] !== 32'h204) begin
        failures++;
        $display("[TB] FAIL rr_write: got addr=%h wstrb=%b wdata=%h next=%h, required 300 0011 0000beef 204",
                 obs_addr[1], obs_wstrb[1], obs_wdata[1], obs_addr[2]);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    slave_lat = 0;
    fork
      drive_req(0, 32'h400, 32'h0, 4'h0, ERR, 1'b1);
      begin
        bit seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
          @(negedge clk);
          seen = mem_valid;
        end
        for (int c = 0; c < 20 && mem_valid; c++) begin
          n++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (n != 4) begin
      failures++;
      $display("[TB] FAIL timeout_valid_len: got %0d cycles, required 4", n);
    end
    checks++;
    if (err_count !== 8'd1) begin
      failures++;
      $display("[TB] FAIL timeout_count_1: got %0d, required 1", err_count);
    end
    for (int i = 2; i <= 300; i++) begin
      drive_req(i % 2, 32'h400 + 32'(i), 32'h0, 4'h0, ERR, 1'b1);
      if (i == 254 || i == 255 || i == 300) begin
        checks++;
        if (err_count !== 8'((i > 255) ? 255 : i)) begin
          failures++;
          $display("[TB] FAIL timeout_count_%0d: got %0d, required %0d", i, err_count, (i > 255) ? 255 : i);
        end
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    slave_lat = 4;
    drive_req(1, 32'h500, 32'h0, 4'h0, sdat(32'h500), 1'b0);
    checks++;
    if (err_count !== 8'd0) begin
      failures++;
      $display("[TB] FAIL boundary_count: got %0d, required 0", err_count);
    end
    @(posedge clk);
    #2;
    mem_ready = 1'b1;
    mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready, bus_error} !== 3'b000 || m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
      failures++;
      $display("[TB] FAIL stray_ready: got rdy=%b%b err=%b rdata=%h/%h, required all 0",
               m0_ready, m1_ready, bus_error, m0_rdata, m1_rdata);
    end
    @(posedge clk);
    #2;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || grant !== 2'b00) begin
      failures++;
      $display("[TB] FAIL stray_idle: got valid=%b grant=%b, required 0 00", mem_valid, grant);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    slave_lat = 0;
    drive_req(0, 32'h600, 32'h0, 4'h0, ERR, 1'b1);
    checks++;
    if (err_count !== 8'd1) begin
      failures++;
      $display("[TB] FAIL pre_reset_count: got %0d, required 1", err_count);
    end
    m1_addr = 32'h700;
    m1_valid = 1'b1;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      seen = (grant == 2'b10);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL mid_grant: got grant=%b, required 10", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_valid, grant, m1_ready, err_count} !== 12'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got valid=%b grant=%b rdy=%b cnt=%0d addr=%h, required all 0",
               mem_valid, grant, m1_ready, err_count, mem_addr);
    end
    m1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    slave_lat = 1;
    @(posedge clk);
    #1;
    fork
      drive_req(0, 32'h800, 32'h0, 4'h0, sdat(32'h800), 1'b0);
      drive_req(1, 32'h900, 32'h0, 4'h0, sdat(32'h900), 1'b0);
    join
    @(negedge clk);
    checks++;
    if (obs_grant.size() < 1 || obs_grant[0] !== 2'b01) begin
      failures++;
      $display("[TB] FAIL post_reset_first: got %p, required 01 first", obs_grant);
    end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_boundary();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
